// File: rtl/disp_pkg.sv
// disp_pkg: shared FSM encoding and 7-segment patterns for the display scanner
package disp_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/display_scan_scheduler_seg7_decoder.sv
// seg7_decoder: hex nibble to active-low {g,f,e,d,c,b,a} segment pattern
module seg7_decoder
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[hex];
endmodule

// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler: multiplexed 7-segment scan with blank guard, frame snapshot and runtime slot length
module display_scan_scheduler
  import disp_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_RATIO = 5000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                  clkin,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  input  logic [31:0]           ratio_in,
  input  logic                  ratio_load,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  state_t state, nstate;
  logic [IW-1:0] idx, nidx;
  logic [31:0] cnt, ncnt, active_ratio, pending, clamped;
  logic pend_v, frame_start, slot_end, last_slot;
  logic [4*DIGITS-1:0] snap_data;
  logic [DIGITS-1:0] snap_dp, blank_mask, n_an;
  logic snap_lz, drive_on, n_dp, z;
  logic [3:0] nib;
  logic [6:0] dec, n_seg;
  seg7_decoder u_dec (
    .hex(nib),
    .seg(dec)
  );
  // Sequencing: en low forces IDLE; a slot is BLANK_CYC dark cycles then drive until active_ratio
  always_comb begin
    nstate = state;
    nidx = idx;
    ncnt = cnt;
    frame_start = 1'b0;
    slot_end = (state == DRIVE) && (cnt >= active_ratio - 32'd1);
    last_slot = idx == IW'(DIGITS - 1);
    if (!en) begin
      nstate = IDLE;
      nidx = '0;
      ncnt = '0;
    end else if (state == IDLE) begin
      nstate = BLANK;
      nidx = '0;
      ncnt = '0;
      frame_start = 1'b1;
    end else if (state == BLANK) begin
      ncnt = cnt + 32'd1;
      nstate = (cnt >= 32'(BLANK_CYC - 1)) ? DRIVE : BLANK;
    end else if (slot_end) begin
      nstate = BLANK;
      ncnt = '0;
      nidx = last_slot ? '0 : idx + 1'b1;
      frame_start = last_slot;
    end else begin
      ncnt = cnt + 32'd1;
    end
  end
  // Leading-zero mask from the snapshot: a digit is blanked while it and everything above it is zero
  always_comb begin
    blank_mask = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z & (snap_data[4*i +: 4] == 4'h0);
      blank_mask[i] = snap_lz & z;
    end
  end
  // Output values for the state being entered, so registered outputs line up with the state
  always_comb begin
    nib = snap_data[{nidx, 2'b00} +: 4];
    drive_on = (nstate == DRIVE) && !blank_mask[nidx];
    n_an = drive_on ? ~(DIGITS'(1) << nidx) : '1;
    n_seg = drive_on ? dec : SEG_BLANK;
    n_dp = !(drive_on && snap_dp[nidx]);
    clamped = (ratio_in <= 32'(BLANK_CYC)) ? 32'(BLANK_CYC + 1) : ratio_in;
  end
  // FSM state, slot counter and registered pin drive
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      an <= '1;
      seg <= SEG_BLANK;
      dp <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state <= nstate;
      idx <= nidx;
      cnt <= ncnt;
      an <= n_an;
      seg <= n_seg;
      dp <= n_dp;
      frame_tick <= frame_start;
    end
  end
  // Per-frame snapshot of display data and deferred slot length update
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      snap_data <= '0;
      snap_dp <= '0;
      snap_lz <= 1'b0;
      active_ratio <= 32'(SCAN_RATIO);
      pending <= '0;
      pend_v <= 1'b0;
    end else begin
      if (frame_start) begin
        snap_data <= digit_data;
        snap_dp <= dp_mask;
        snap_lz <= blank_lz;
        if (pend_v) active_ratio <= pending;
        pend_v <= 1'b0;
      end
      if (ratio_load && ratio_in != 32'd0) begin
        pending <= clamped;
        pend_v <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_display_scan_scheduler.sv
// tb_display_scan_scheduler: directed checks of scan timing, blanking, snapshot, ratio loads and reset
module tb_display_scan_scheduler;
  logic clk = 1'b0;
  logic rst, en, blank_lz, ratio_load;
  logic [15:0] digit_data;
  logic [3:0] dp_mask;
  logic [31:0] ratio_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp, frame_tick;
  int checks = 0;
  int errors = 0;
  int n;
  logic [3:0] low_seen, dp_seen;
  logic [6:0] seg_seen [4];
  int drive_len [4];
  display_scan_scheduler #(.DIGITS(4), .SCAN_RATIO(10), .BLANK_CYC(2)) dut (
    .clkin(clk),
    .rst(rst),
    .en(en),
    .digit_data(digit_data),
    .dp_mask(dp_mask),
    .blank_lz(blank_lz),
    .ratio_in(ratio_in),
    .ratio_load(ratio_load),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic wait_ft(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (frame_tick !== 1'b1 && cyc < 200);
    if (cyc >= 200) chk("ft_timeout", {31'd0, frame_tick}, 32'd1);
  endtask
  task automatic observe(input int k);
    low_seen = '0;
    dp_seen = '0;
    for (int d = 0; d < 4; d++) begin
      seg_seen[d] = 7'h7F;
      drive_len[d] = 0;
    end
    for (int i = 0; i < k; i++) begin
      for (int d = 0; d < 4; d++)
        if (an[d] === 1'b0) begin
          low_seen[d] = 1'b1;
          seg_seen[d] = seg;
          if (dp === 1'b0) dp_seen[d] = 1'b1;
          drive_len[d]++;
        end
      @(negedge clk);
    end
  endtask
  initial begin
    rst = 1'b1; en = 1'b1; digit_data = 16'h1234; dp_mask = 4'h0;
    blank_lz = 1'b0; ratio_in = 32'd0; ratio_load = 1'b0;
    tick(2);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_ft", {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;
    tick(1);
    chk("t1_ft_first", {31'd0, frame_tick}, 32'd1);
    chk("t1_blank_an", {28'd0, an}, 32'hF);
    tick(2);
    chk("t1_d0_an", {28'd0, an}, 32'hE);
    chk("t1_d0_seg", {25'd0, seg}, 32'h19);
    chk("t1_ft_low", {31'd0, frame_tick}, 32'd0);
    tick(7);
    chk("t1_d0_last", {28'd0, an}, 32'hE);
    tick(1);
    chk("t1_guard", {28'd0, an}, 32'hF);
    tick(2);
    chk("t1_d1_an", {28'd0, an}, 32'hD);
    chk("t1_d1_seg", {25'd0, seg}, 32'h30);
    wait_ft(n);
    wait_ft(n);
    chk("t1_period", n, 40);
    blank_lz = 1'b1; digit_data = 16'h0050; dp_mask = 4'hF;
    wait_ft(n);
    observe(40);
    chk("t2_lz_low", {28'd0, low_seen}, 32'h3);
    chk("t2_d1_seg", {25'd0, seg_seen[1]}, 32'h12);
    chk("t2_d0_seg", {25'd0, seg_seen[0]}, 32'h40);
    chk("t2_dp_supp", {28'd0, dp_seen}, 32'h3);
    chk("t2_drive_len", drive_len[0], 8);
    digit_data = 16'h0000; dp_mask = 4'h0;
    wait_ft(n);
    observe(40);
    chk("t2_zero_low", {28'd0, low_seen}, 32'h1);
    chk("t2_zero_seg", {25'd0, seg_seen[0]}, 32'h40);
    blank_lz = 1'b0; digit_data = 16'h1234;
    tick(5);
    ratio_in = 32'd6; ratio_load = 1'b1;
    tick(1);
    ratio_load = 1'b0;
    wait_ft(n);
    chk("t3_keep_frame", n, 34);
    wait_ft(n);
    chk("t3_period6", n, 24);
    ratio_in = 32'd1; ratio_load = 1'b1;
    tick(1);
    ratio_load = 1'b0;
    wait_ft(n);
    chk("t3_before_clamp", n, 23);
    wait_ft(n);
    chk("t3_clamp", n, 12);
    ratio_in = 32'd0; ratio_load = 1'b1;
    tick(1);
    ratio_load = 1'b0;
    wait_ft(n);
    wait_ft(n);
    chk("t3_zero_ignored", n, 12);
    tick(11);
    ratio_in = 32'd10; ratio_load = 1'b1;
    tick(1);
    chk("t3_boundary_ft", {31'd0, frame_tick}, 32'd1);
    ratio_load = 1'b0;
    wait_ft(n);
    chk("t3_boundary_defer", n, 12);
    wait_ft(n);
    chk("t3_boundary_apply", n, 40);
    tick(5);
    digit_data = 16'h5678;
    observe(35);
    chk("t4_old_d3", {25'd0, seg_seen[3]}, 32'h79);
    chk("t4_old_d0", {25'd0, seg_seen[0]}, 32'h19);
    chk("t4_at_ft", {31'd0, frame_tick}, 32'd1);
    observe(40);
    chk("t4_new_d3", {25'd0, seg_seen[3]}, 32'h12);
    chk("t4_new_d0", {25'd0, seg_seen[0]}, 32'h00);
    tick(24);
    chk("t5_d2_drive", {28'd0, an}, 32'hB);
    en = 1'b0;
    tick(1);
    chk("t5_dark", {28'd0, an}, 32'hF);
    chk("t5_seg_dark", {25'd0, seg}, 32'h7F);
    dp_mask = 4'h1;
    tick(3);
    chk("t5_idle_ft", {31'd0, frame_tick}, 32'd0);
    en = 1'b1;
    tick(1);
    chk("t5_restart_ft", {31'd0, frame_tick}, 32'd1);
    tick(2);
    chk("t5_restart_d0", {28'd0, an}, 32'hE);
    chk("t5_dp_lit", {31'd0, dp}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_an", {28'd0, an}, 32'hF);
    chk("t6_seg", {25'd0, seg}, 32'h7F);
    chk("t6_dp", {31'd0, dp}, 32'd1);
    chk("t6_ft", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    chk("t6_restart_ft", {31'd0, frame_tick}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
